// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS fetch-path program-counter controller.
// Holds the architectural PC and forms the next fetch address: sequential,
// branch, J-type concatenation or jump-register. It also sequences
// instruction-memory requests through a req/ack handshake with stall, and
// keeps a one-entry buffer for redirects that arrive while no fetch is being
// accepted.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jumpIndex,
    input  logic        jumpReg,
    input  logic [31:0] regTarget,
    input  logic        branchTaken,
    input  logic [15:0] branchOffset,
    output logic        imemReq,
    input  logic        imemAck,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        pcValid,
    output logic [31:0] fetchPc,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] fetch_pc_q;
    logic        imem_req_q;
    logic        pc_valid_q;
    logic        misaligned_q;

    // One-entry pending redirect: target plus a flag recording that it came
    // from a misaligned JR, so misaligned is raised only once it is applied.
    logic        pend_vld_q;
    logic [31:0] pend_tgt_q;
    logic        pend_mis_q;

    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] jr_tgt;
    logic        redir_vld;
    logic [31:0] redir_tgt;
    logic        redir_mis;
    logic        accept;
    logic [31:0] pc_d;
    logic        mis_d;

    assign pcPlus4 = pc_q + 32'd4;

    assign jump_tgt   = {pcPlus4[31:28], jumpIndex, 2'b00};
    assign branch_tgt = pcPlus4 + {{14{branchOffset[15]}}, branchOffset, 2'b00};
    assign jr_tgt     = {regTarget[31:2], 2'b00};

    // Select this cycle's redirect by priority: jumpReg, then jump, then branch.
    always_comb begin
        redir_vld = 1'b0;
        redir_tgt = pcPlus4;
        redir_mis = 1'b0;
        if (jumpReg) begin
            redir_vld = 1'b1;
            redir_tgt = jr_tgt;
            redir_mis = (regTarget[1:0] != 2'b00);
        end else if (jump) begin
            redir_vld = 1'b1;
            redir_tgt = jump_tgt;
        end else if (branchTaken) begin
            redir_vld = 1'b1;
            redir_tgt = branch_tgt;
        end
    end

    // A fetch is accepted only while requesting, acked, and not stalled.
    // When stall and ack arrive together, stall wins.
    assign accept = (state_q == REQ) && imemAck && !stall;

    // Form the next PC. A same-cycle redirect beats a pending one, and a
    // pending redirect beats the sequential address.
    always_comb begin
        pc_d  = pcPlus4;
        mis_d = 1'b0;
        if (redir_vld) begin
            pc_d  = redir_tgt;
            mis_d = redir_mis;
        end else if (pend_vld_q) begin
            pc_d  = pend_tgt_q;
            mis_d = pend_mis_q;
        end
    end

    // Control FSM: sequences requests and updates the PC and fetch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            imem_req_q   <= 1'b0;
            pc_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q    <= stall ? HOLD : REQ;
                    imem_req_q <= !stall;
                end
                REQ: begin
                    if (stall) begin
                        state_q    <= HOLD;
                        imem_req_q <= 1'b0;
                    end else if (imemAck) begin
                        pc_q         <= pc_d;
                        fetch_pc_q   <= pc_q;
                        pc_valid_q   <= 1'b1;
                        misaligned_q <= misaligned_q | mis_d;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_q    <= REQ;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Pending redirect: capture pulses not consumed by an accepted fetch.
    // A newer pulse overwrites an older entry. Any accepted fetch empties the
    // buffer, either by using the entry or by a same-cycle redirect that
    // supersedes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_tgt_q <= RESET_PC;
            pend_mis_q <= 1'b0;
        end else if (accept) begin
            pend_vld_q <= 1'b0;
            pend_mis_q <= 1'b0;
        end else if (redir_vld) begin
            pend_vld_q <= 1'b1;
            pend_tgt_q <= redir_tgt;
            pend_mis_q <= redir_mis;
        end
    end

    // Stall suppresses the request in the same cycle it is raised, so no
    // request is seen while the fetch is held.
    assign imemReq    = imem_req_q & ~stall;
    assign pc         = pc_q;
    assign pcValid    = pc_valid_q;
    assign fetchPc    = fetch_pc_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: per-cycle vector table plus hand-written
// sequences for PC wrap and reset with a pending redirect.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [25:0] jumpIndex;
    logic        jumpReg;
    logic [31:0] regTarget;
    logic        branchTaken;
    logic [15:0] branchOffset;
    logic        imemReq;
    logic        imemAck;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        pcValid;
    logic [31:0] fetchPc;
    logic        misaligned;

    int total;
    int bad;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .jump(jump),
        .jumpIndex(jumpIndex),
        .jumpReg(jumpReg),
        .regTarget(regTarget),
        .branchTaken(branchTaken),
        .branchOffset(branchOffset),
        .imemReq(imemReq),
        .imemAck(imemAck),
        .pc(pc),
        .pcPlus4(pcPlus4),
        .pcValid(pcValid),
        .fetchPc(fetchPc),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jump;
        logic [25:0] ji;
        logic        jr;
        logic [31:0] rt;
        logic        bt;
        logic [15:0] bo;
        logic        ack;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_fpc;
        logic        e_mis;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    function automatic vec_t mk(
        input logic st, input logic j, input logic [25:0] ji,
        input logic jr, input logic [31:0] rt,
        input logic bt, input logic [15:0] bo, input logic ack,
        input logic e_req, input logic [31:0] e_pc, input logic e_v,
        input logic [31:0] e_fpc, input logic e_mis);
        vec_t v;
        v.stall = st;  v.jump = j;   v.ji = ji;  v.jr = jr;  v.rt = rt;
        v.bt = bt;     v.bo = bo;    v.ack = ack;
        v.e_req = e_req; v.e_pc = e_pc; v.e_v = e_v;
        v.e_fpc = e_fpc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; jump = 1'b0; jumpIndex = '0; jumpReg = 1'b0;
        regTarget = '0; branchTaken = 1'b0; branchOffset = '0; imemAck = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;

        // Each row: inputs driven during the cycle, outputs expected during it.
        //          st j  ji            jr rt             bt bo        ack  req pc             v  fetchPc        mis
        vt[0]  = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   0, 32'h0000_0000, 0, 32'h0000_0000, 0);
        vt[1]  = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h0000_0000, 0, 32'h0000_0000, 0);
        vt[2]  = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h0000_0004, 1, 32'h0000_0000, 0);
        vt[3]  = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h0000_0008, 1, 32'h0000_0004, 0);
        vt[4]  = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h0000_000C, 1, 32'h0000_0008, 0);
        vt[5]  = mk(0, 0, 26'h0,        1, 32'h4000_0010, 0, 16'h0,    1,   1, 32'h0000_0010, 1, 32'h0000_000C, 0);
        vt[6]  = mk(0, 1, 26'h0000100,  0, 32'h0,         0, 16'h0,    1,   1, 32'h4000_0010, 1, 32'h0000_0010, 0);
        vt[7]  = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h4000_0400, 1, 32'h4000_0010, 0);
        vt[8]  = mk(0, 0, 26'h0,        1, 32'h0000_0100, 0, 16'h0,    1,   1, 32'h4000_0404, 1, 32'h4000_0400, 0);
        vt[9]  = mk(0, 0, 26'h0,        0, 32'h0,         1, 16'hFFFE, 0,   1, 32'h0000_0100, 1, 32'h4000_0404, 0);
        vt[10] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    0,   1, 32'h0000_0100, 0, 32'h4000_0404, 0);
        vt[11] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    0,   1, 32'h0000_0100, 0, 32'h4000_0404, 0);
        vt[12] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h0000_0100, 0, 32'h4000_0404, 0);
        vt[13] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h0000_00FC, 1, 32'h0000_0100, 0);
        vt[14] = mk(0, 1, 26'h3FFFFFF,  1, 32'h0000_2002, 1, 16'h0010, 1,   1, 32'h0000_0100, 1, 32'h0000_00FC, 0);
        vt[15] = mk(1, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   0, 32'h0000_2000, 1, 32'h0000_0100, 1);
        vt[16] = mk(1, 1, 26'h0000010,  0, 32'h0,         0, 16'h0,    1,   0, 32'h0000_2000, 0, 32'h0000_0100, 1);
        vt[17] = mk(1, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   0, 32'h0000_2000, 0, 32'h0000_0100, 1);
        vt[18] = mk(1, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   0, 32'h0000_2000, 0, 32'h0000_0100, 1);
        vt[19] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   0, 32'h0000_2000, 0, 32'h0000_0100, 1);
        vt[20] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    1,   1, 32'h0000_2000, 0, 32'h0000_0100, 1);
        vt[21] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    0,   1, 32'h0000_0040, 1, 32'h0000_2000, 1);
        vt[22] = mk(0, 0, 26'h0,        0, 32'h0,         0, 16'h0,    0,   1, 32'h0000_0040, 0, 32'h0000_2000, 1);

        // Reset state while rst_n is held low.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetchPc", fetchPc, 32'h0);
        chk("rst_imemReq", {31'd0, imemReq}, 32'd0);
        chk("rst_pcValid", {31'd0, pcValid}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);

        // Release at a negedge: this begins cycle 1 (row 0).
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            stall        = vt[i].stall;
            jump         = vt[i].jump;
            jumpIndex    = vt[i].ji;
            jumpReg      = vt[i].jr;
            regTarget    = vt[i].rt;
            branchTaken  = vt[i].bt;
            branchOffset = vt[i].bo;
            imemAck      = vt[i].ack;
            #1;
            chk($sformatf("c%0d_imemReq", i + 1), {31'd0, imemReq}, {31'd0, vt[i].e_req});
            chk($sformatf("c%0d_pc", i + 1), pc, vt[i].e_pc);
            chk($sformatf("c%0d_pcPlus4", i + 1), pcPlus4, vt[i].e_pc + 32'd4);
            chk($sformatf("c%0d_pcValid", i + 1), {31'd0, pcValid}, {31'd0, vt[i].e_v});
            chk($sformatf("c%0d_fetchPc", i + 1), fetchPc, vt[i].e_fpc);
            chk($sformatf("c%0d_misaligned", i + 1), {31'd0, misaligned}, {31'd0, vt[i].e_mis});
            next_cycle();
        end

        // Sequential wrap: JR to the top word, then one sequential fetch.
        idle_inputs();
        jumpReg = 1'b1; regTarget = 32'hFFFF_FFFC; imemAck = 1'b1;
        next_cycle();
        idle_inputs();
        #1;
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        chk("wrap_pcPlus4", pcPlus4, 32'h0000_0000);
        imemAck = 1'b1;
        next_cycle();
        #1;
        chk("wrap_pc_zero", pc, 32'h0000_0000);
        chk("wrap_fetchPc", fetchPc, 32'hFFFF_FFFC);
        chk("wrap_pcValid", {31'd0, pcValid}, 32'd1);
        next_cycle();
        #1;
        chk("wrap_pc_4", pc, 32'h0000_0004);

        // Capture a jump as a pending redirect, then reset mid-cycle.
        imemAck = 1'b0; jump = 1'b1; jumpIndex = 26'h0000055;
        next_cycle();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0000_0000);
        chk("midrst_imemReq", {31'd0, imemReq}, 32'd0);
        chk("midrst_pcValid", {31'd0, pcValid}, 32'd0);
        chk("midrst_misaligned", {31'd0, misaligned}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        imemAck = 1'b1;
        #1;
        chk("post_rst_c1_imemReq", {31'd0, imemReq}, 32'd0);
        next_cycle();
        #1;
        chk("post_rst_c2_imemReq", {31'd0, imemReq}, 32'd1);
        chk("post_rst_c2_pc", pc, 32'h0000_0000);
        next_cycle();
        #1;
        chk("post_rst_seq_pc", pc, 32'h0000_0004);
        chk("post_rst_fetchPc", fetchPc, 32'h0000_0000);
        chk("post_rst_misaligned", {31'd0, misaligned}, 32'd0);

        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
